// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial |a-b| unit: state encoding, default
// width and the bit-counter width.
package serial_subtractor_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SUB  = 2'd1;
   localparam logic [1:0] ST_NEG  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Counter width for an arbitrary WIDTH (at least one bit).
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: a - b - borrow_in.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic borrow_in,
   output logic difference,
   output logic borrow_out
);

   assign difference = a ^ b ^ borrow_in;
   assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial sign-magnitude subtractor: one LSB-first pass for a-b and,
// when that borrows, a second pass through the same cell computing 0-raw.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] magnitude,
   output logic             negative,
   output logic             borrow_out,
   output logic             busy
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] mag_q, mag_d;
   logic             neg_q, neg_d;
   logic             bo_q, bo_d;
   logic             brw_q, brw_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             fs_a, fs_b, fs_diff, fs_bo;
   logic [WIDTH-1:0] res_shift;

   // Same cell for both passes; NEG pass computes 0 - raw result.
   always_comb begin
      fs_a = a_sh_q[0];
      fs_b = b_sh_q[0];
      if (state_q == ST_NEG) begin
         fs_a = 1'b0;
         fs_b = res_q[0];
      end
   end

   full_subtractor u_fs (
      .a          (fs_a),
      .b          (fs_b),
      .borrow_in  (brw_q),
      .difference (fs_diff),
      .borrow_out (fs_bo)
   );

   assign res_shift = {fs_diff, res_q[WIDTH-1:1]};

   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      res_d       = res_q;
      mag_d       = mag_q;
      neg_d       = neg_q;
      bo_d        = bo_q;
      brw_d       = brw_q;
      cnt_d       = cnt_q;
      case (state_q)
         ST_IDLE: begin
            in_ready_d = 1'b1;
            if (in_valid && in_ready_q) begin
               a_sh_d     = a;
               b_sh_d     = b;
               cnt_d      = '0;
               brw_d      = 1'b0;
               in_ready_d = 1'b0;
               state_d    = ST_SUB;
            end
         end
         ST_SUB: begin
            res_d  = res_shift;
            a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
            brw_d  = fs_bo;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               neg_d = fs_bo;
               bo_d  = fs_bo;
               if (fs_bo) begin
                  cnt_d   = '0;
                  brw_d   = 1'b0;
                  state_d = ST_NEG;
               end else begin
                  mag_d       = res_shift;
                  out_valid_d = 1'b1;
                  state_d     = ST_DONE;
               end
            end
         end
         ST_NEG: begin
            res_d = res_shift;
            brw_d = fs_bo;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               mag_d       = res_shift;
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         res_q       <= '0;
         mag_q       <= '0;
         neg_q       <= 1'b0;
         bo_q        <= 1'b0;
         brw_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         res_q       <= res_d;
         mag_q       <= mag_d;
         neg_q       <= neg_d;
         bo_q        <= bo_d;
         brw_q       <= brw_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign magnitude  = mag_q;
   assign negative   = neg_q;
   assign borrow_out = bo_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial, multi-cycle subtract unit that produces |a-b| plus a sign flag.
- Captures two WIDTH-bit operands through a valid/ready handshake.
- Streams the operands LSB-first through a single full_subtractor cell.
- When the raw result borrows, makes a second serial pass through the same cell, computing 0 - raw, to return sign-magnitude.
- Sits downstream of operand sources and upstream of consumers that need registered results.

Parameters:
WIDTH, 4, operand and magnitude width in bits (legal range 2 to 32)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a/b are valid this cycle
in_ready  output  1  block can accept operands (registered)
a  input  WIDTH  minuend, unsigned
b  input  WIDTH  subtrahend, unsigned
out_valid  output  1  result fields are valid and held stable
out_ready  input  1  downstream accepts the result
magnitude  output  WIDTH  |a-b|
negative  output  1  1 when a<b
borrow_out  output  1  raw borrow of a-b (equals negative; kept for chaining)
busy  output  1  1 in every state except IDLE

Behaviour:
- Clock and reset: one clock (clk). Reset (rst_n) is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=0, out_valid=0, magnitude=0, negative=0, borrow_out=0, busy=0.
- The first rising edge after rst_n deasserts sets in_ready=1.
- States: IDLE, SUB, NEG, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&in_ready: load the a and b shift registers, clear the bit counter, clear the borrow register, set in_ready=0, go to SUB.
- SUB (exactly WIDTH edges):
  - Each edge feeds a[i], b[i] and the registered borrow into full_subtractor.
  - The difference bit shifts MSB-in into the result register; the borrow is registered.
  - The borrow into bit 0 is 0.
  - On the WIDTH-th edge: borrow_out and negative take the final borrow.
  - Final borrow 0 goes to DONE. Final borrow 1 goes to NEG with the counter and borrow register cleared.
- NEG (exactly WIDTH edges):
  - Each edge feeds a=0, b=result[0] and the registered borrow into the same full_subtractor.
  - The result shifts right with the difference entering at the MSB, so the result becomes the two's complement (b-a).
  - The final borrow of this pass is discarded. The WIDTH-th edge goes to DONE.
- DONE:
  - out_valid=1. magnitude, negative and borrow_out stay stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: out_valid goes to 0, in_ready goes to 1, state goes to IDLE.
  - The output fields retain their last values until the next completion.
- Latency:
  - Measured from the accepting edge, out_valid rises after WIDTH edges when a>=b, and after 2*WIDTH edges when a<b.
  - Minimum turnaround is WIDTH+2 cycles per operation. There is no back-to-back accept in DONE.
- Width rule: magnitude always fits in WIDTH bits, because 0 <= |a-b| <= 2^WIDTH-1. No overflow flag.
- Boundaries:
  - a==b gives magnitude 0, negative 0, and no NEG pass.
  - a=0, b=2^WIDTH-1 gives magnitude 2^WIDTH-1, negative 1.
  - in_valid while busy: ignored, operands not sampled.
  - out_ready high before DONE: no effect.
  - Operand changes after acceptance do not affect the result.
- Reset mid-operation (any state): everything returns to reset values immediately. The in-flight result is lost and out_valid never rises for it.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=0, SUB=1, NEG=2, DONE=3, 2-bit);
  - the WIDTH default;
  - the counter-width constant, clog2(WIDTH).
- One sub-module: the existing full_subtractor (a, b, borrow_in -> difference, borrow_out), instantiated once.
- Its input muxing (operand vs. zero/result bit) lives in serial_subtractor.

Test Plan:
- WIDTH=4, a=9, b=3, out_ready=1 -> out_valid exactly 4 cycles after accept; magnitude=6, negative=0, borrow_out=0; in_ready back to 1 the next cycle.
- a=3, b=9 -> out_valid 8 cycles after accept; magnitude=6, negative=1, borrow_out=1.
- a=7, b=7, then a=0, b=15 -> first result magnitude=0, negative=0 after 4 cycles; second result magnitude=15, negative=1 after 8 cycles.
- a=12, b=5 with out_ready=0 for 5 cycles in DONE, and in_valid=1 with a=1, b=2 pulsed during SUB and DONE:
  - in_ready stays 0 and the new operands are ignored;
  - out_valid=1 and magnitude=7 are held stable;
  - the result completes on the first edge with out_ready=1.
- a=2, b=10, rst_n pulled low on the 3rd NEG cycle:
  - all outputs go to 0 asynchronously and out_valid never asserts;
  - in_ready=1 one edge after release;
  - a fresh op a=10, b=2 then gives magnitude=8, negative=0.
- Exhaustive sweep, WIDTH=4, all 256 (a,b) pairs with random out_ready stalls: magnitude==|a-b| and negative==(a<b) for every pair.
